// File: rtl/boot_loader.sv
// boot_loader: copies a BIOS image word by word into target memory, keeping a word count and
// additive checksum, and pulses done when the copy has finished.
module boot_loader #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_base,
    input  logic [ADDR_WIDTH-1:0] dst_base,
    input  logic [ADDR_WIDTH:0]   length,
    output logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [DATA_WIDTH-1:0] src_q,
    output logic [ADDR_WIDTH-1:0] dst_addr,
    output logic [DATA_WIDTH-1:0] dst_data,
    output logic                  dst_we,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   words_copied,
    output logic [DATA_WIDTH-1:0] checksum
);
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, STORE, FINISH} state_t;
    state_t state, state_nx;
    logic [ADDR_WIDTH:0] len_r;
    logic [1:0] wcnt;
    logic last_wait, last_word;
    assign last_wait = wcnt == 2'(READ_LATENCY - 1);
    assign last_word = words_copied + (ADDR_WIDTH + 1)'(1) == len_r;
    assign dst_we = state == STORE;
    assign busy = state != IDLE;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = length == '0 ? FINISH : FETCH;
            FETCH:   state_nx = WAIT;
            WAIT:    state_nx = last_wait ? STORE : WAIT;
            STORE:   state_nx = last_word ? FINISH : FETCH;
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end
    // Address registers advance after each store so they already point at the next word;
    // after the last store they hold the final addresses.
    always_ff @(posedge clk) begin
        if (reset) begin
            src_addr     <= '0;
            dst_addr     <= '0;
            dst_data     <= '0;
            words_copied <= '0;
            checksum     <= '0;
            len_r        <= '0;
            wcnt         <= '0;
            done         <= 1'b0;
        end else begin
            done <= state == FINISH;
            case (state)
                IDLE: if (start) begin
                    src_addr     <= src_base;
                    dst_addr     <= dst_base;
                    len_r        <= length;
                    words_copied <= '0;
                    checksum     <= '0;
                end
                FETCH: wcnt <= '0;
                WAIT: begin
                    wcnt <= wcnt + 2'd1;
                    if (last_wait) dst_data <= src_q;
                end
                STORE: begin
                    words_copied <= words_copied + (ADDR_WIDTH + 1)'(1);
                    checksum     <= checksum + dst_data;
                    if (!last_word) begin
                        src_addr <= src_addr + ADDR_WIDTH'(1);
                        dst_addr <= dst_addr + ADDR_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: drives two boot_loader instances (read latency 1 and 3) with identical stimulus
// and checks every cycle against a timing/arithmetic model of the copy.
module tb_boot_loader;
    localparam int P[2] = '{3, 5};
    localparam int RL[2] = '{1, 3};

    logic clk = 0, reset = 1, start = 0;
    logic [9:0] src_base = 0, dst_base = 0;
    logic [10:0] length = 0;
    logic [9:0] src_addr[2], dst_addr[2];
    logic [31:0] src_q[2], dst_data[2], checksum[2];
    logic dst_we[2], busy[2], done[2];
    logic [10:0] words_copied[2];
    logic [31:0] bios[1024];
    logic [31:0] pipe[2][3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        boot_loader #(.READ_LATENCY(g == 0 ? 1 : 3)) dut (
            .clk(clk), .reset(reset), .start(start), .src_base(src_base), .dst_base(dst_base),
            .length(length), .src_addr(src_addr[g]), .src_q(src_q[g]), .dst_addr(dst_addr[g]),
            .dst_data(dst_data[g]), .dst_we(dst_we[g]), .busy(busy[g]), .done(done[g]),
            .words_copied(words_copied[g]), .checksum(checksum[g])
        );
    end

    always @(posedge clk)
        for (int i = 0; i < 2; i++) begin
            pipe[i][0] <= bios[src_addr[i]];
            pipe[i][1] <= pipe[i][0];
            pipe[i][2] <= pipe[i][1];
        end
    assign src_q[0] = pipe[0][0];
    assign src_q[1] = pipe[1][2];

    int passed = 0, total = 0, cyc = 0, c_start = 0;
    int done_cyc[2];
    bit act[2];
    int t0[2], nw[2], sb[2], db[2];
    logic [31:0] img[2][64];

    task automatic chk(string nm, int i, logic [63:0] a, logic [63:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s inst%0d cyc %0d: got %0h expected %0h", nm, i, cyc, a, e);
    endtask

    task automatic model_step;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (reset) act[i] = 0;
            else if ((!act[i] || (cyc - 1 - t0[i]) >= nw[i] * P[i] + 2) && start) begin
                act[i] = 1;
                t0[i] = cyc - 1;
                nw[i] = int'(length);
                sb[i] = int'(src_base);
                db[i] = int'(dst_base);
                for (int k = 0; k < 64; k++) img[i][k] = bios[(sb[i] + k) % 1024];
            end
        end
    endtask

    task automatic compare;
        for (int i = 0; i < 2; i++) begin
            int rel, np, wc, k;
            logic [31:0] cs;
            logic e_busy, e_done, e_we;
            e_busy = 0; e_done = 0; e_we = 0; wc = 0; cs = 0; rel = 0; np = 0;
            if (act[i]) begin
                rel = cyc - t0[i];
                np = nw[i] * P[i];
                e_busy = rel <= np + 1;
                e_done = rel == np + 2;
                e_we = rel % P[i] == 0 && rel <= np;
                wc = (rel - 1) / P[i] > nw[i] ? nw[i] : (rel - 1) / P[i];
                for (int j = 0; j < wc; j++) cs += img[i][j];
            end
            if (done[i] === 1'b1) done_cyc[i] = cyc;
            chk("busy", i, 64'(busy[i]), 64'(e_busy));
            chk("done", i, 64'(done[i]), 64'(e_done));
            chk("dst_we", i, 64'(dst_we[i]), 64'(e_we));
            chk("words_copied", i, 64'(words_copied[i]), 64'(wc));
            chk("checksum", i, 64'(checksum[i]), 64'(cs));
            if (e_we) begin
                k = rel / P[i] - 1;
                chk("dst_addr", i, 64'(dst_addr[i]), 64'((db[i] + k) % 1024));
                chk("dst_data", i, 64'(dst_data[i]), 64'(img[i][k]));
            end
            if (act[i] && rel <= np && (rel - 1) % P[i] <= RL[i])
                chk("src_addr", i, 64'(src_addr[i]), 64'((sb[i] + (rel - 1) / P[i]) % 1024));
        end
    endtask

    task automatic tick;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic go(input int s, input int d, input int n);
        src_base = 10'(s); dst_base = 10'(d); length = 11'(n);
        done_cyc = '{-1, -1};
        c_start = cyc;
        start = 1;
        tick();
        start = 0;
        repeat (n * 5 + 4) tick();
    endtask

    task automatic lat(input int l0, input int l1);
        chk("latency", 0, 64'(done_cyc[0] - c_start), 64'(l0));
        chk("latency", 1, 64'(done_cyc[1] - c_start), 64'(l1));
    endtask

    initial begin
        for (int k = 0; k < 1024; k++) bios[k] = 32'hA5000000 + k;
        bios[0] = 32'h11; bios[1] = 32'h22; bios[2] = 32'h33;
        bios[50] = 32'hFFFFFFFF; bios[51] = 32'h2;
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            chk("rst_src_addr", i, 64'(src_addr[i]), 0);
            chk("rst_dst_addr", i, 64'(dst_addr[i]), 0);
            chk("rst_dst_data", i, 64'(dst_data[i]), 0);
        end
        reset = 0;
        tick();
        go(0, 8, 3);
        lat(11, 17);
        for (int i = 0; i < 2; i++) begin
            chk("t1_wc", i, 64'(words_copied[i]), 3);
            chk("t1_cs", i, 64'(checksum[i]), 64'h66);
        end
        go(5, 5, 0);
        lat(2, 2);
        chk("t2_wc", 0, 64'(words_copied[0]), 0);
        chk("t2_cs", 0, 64'(checksum[0]), 0);
        go(1023, 1022, 3);
        chk("t3_dst_addr", 0, 64'(dst_addr[0]), 0);
        chk("t3_src_addr", 0, 64'(src_addr[0]), 1);
        chk("t3_cs", 0, 64'(checksum[0]), 64'hA5000432);
        src_base = 0; dst_base = 20; length = 3;
        start = 1;
        tick();
        start = 0;
        repeat (4) tick();
        src_base = 100; dst_base = 200; length = 7;
        start = 1;
        repeat (2) tick();
        start = 0;
        repeat (13) tick();
        for (int i = 0; i < 2; i++) begin
            chk("t4_wc", i, 64'(words_copied[i]), 3);
            chk("t4_cs", i, 64'(checksum[i]), 64'h66);
        end
        src_base = 10; dst_base = 40; length = 5;
        start = 1;
        tick();
        start = 0;
        repeat (5) tick();
        reset = 1;
        tick();
        reset = 0;
        chk("t5_busy", 0, 64'(busy[0]), 0);
        chk("t5_wc", 0, 64'(words_copied[0]), 0);
        chk("t5_dst_data", 0, 64'(dst_data[0]), 0);
        repeat (3) tick();
        go(10, 40, 5);
        chk("t5_wc2", 1, 64'(words_copied[1]), 5);
        chk("t5_cs2", 1, 64'(checksum[1]), 64'h3900003C);
        go(50, 60, 2);
        lat(8, 12);
        for (int i = 0; i < 2; i++) chk("t6_cs", i, 64'(checksum[i]), 1);
        src_base = 1; dst_base = 30; length = 1;
        start = 1;
        repeat (9) tick();
        start = 0;
        repeat (12) tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
